cia_timer_bank: RTL and testbench

Parametrised multi-channel interval timer with a CIA-compatible bus and interrupt control. It generalises the CIA timer A/B pair to `NUM_TIMERS` channels. Each channel has a selectable count source, including cascade from the previous channel and gated CNT. It sits on the same phi2-strobed peripheral bus as the CIA and drives a shared `irq_n` plus per-channel timer outputs.

---
 rtl/cia_timer_bank.sv | 196 +++++++++++++++++++
 tb/tb_cia_timer_bank.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cia_timer_bank.sv
// cia_timer_bank: NUM_TIMERS CIA-style 16-bit interval timers with phi2, CNT and
// cascade count sources, a shared ICR interrupt block and a phi2-strobed bus.
module cia_timer_bank #(
  parameter int NUM_TIMERS     = 4,
  parameter bit RELOAD_ON_STOP = 1'b0
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  phi2_p,
  input  logic                  phi2_n,
  input  logic                  cs_n,
  input  logic                  rw,
  input  logic [4:0]            rs,
  input  logic [7:0]            db_in,
  output logic [7:0]            db_out,
  input  logic                  cnt_in,
  output logic [NUM_TIMERS-1:0] tout,
  output logic                  irq_n
);
  localparam int N = NUM_TIMERS;

  logic [15:0]  latch_q [N];
  logic [15:0]  latch_d [N];
  logic [15:0]  cnt_q [N];
  logic [15:0]  cnt_d [N];
  logic [1:0]   src_q [N];
  logic [1:0]   src_d [N];
  logic [N-1:0] start_q, start_d, armed_q, armed_d, outen_q, outen_d;
  logic [N-1:0] tgl_q, tgl_d, oneshot_q, oneshot_d, loadp_q, loadp_d;
  logic [N-1:0] tff_q, tff_d, pulse_q, pulse_d;
  logic [6:0]   flags_q, flags_d, mask_q, mask_d;
  logic         irq_q, irq_d, clrp_q, clrp_d;
  logic         cnt_prev_q, cntp_q, cntp_d;
  logic [7:0]   db_q, db_d;

  logic         rd_en, wr_en, cnt_edge, prev_uf;
  logic [N-1:0] ev, uf;

  assign rd_en    = phi2_n & ~cs_n & rw;
  assign wr_en    = phi2_n & ~cs_n & ~rw;
  assign cnt_edge = cnt_in & ~cnt_prev_q;

  // Count events ripple down the cascade chain within a single phi2 edge.
  always_comb begin
    ev      = '0;
    uf      = '0;
    prev_uf = 1'b0;
    for (int i = 0; i < N; i++) begin
      case (src_q[i])
        2'b00:   ev[i] = 1'b1;
        2'b01:   ev[i] = cntp_q;
        2'b10:   ev[i] = prev_uf;
        default: ev[i] = prev_uf & cnt_in;
      endcase
      ev[i]   = ev[i] & start_q[i] & armed_q[i];
      uf[i]   = ev[i] & (cnt_q[i] == 16'h0000);
      prev_uf = uf[i];
    end
  end

  always_comb begin
    latch_d   = latch_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    start_d   = start_q;
    armed_d   = armed_q;
    outen_d   = outen_q;
    tgl_d     = tgl_q;
    oneshot_d = oneshot_q;
    loadp_d   = loadp_q;
    tff_d     = tff_q;
    pulse_d   = pulse_q;
    flags_d   = flags_q;
    mask_d    = mask_q;
    irq_d     = irq_q;
    clrp_d    = clrp_q;
    db_d      = db_q;
    cntp_d    = cnt_edge | (cntp_q & ~phi2_p);

    if (phi2_p) begin
      // irq sees the flags as they stood before this edge, hence the one-tick lag.
      irq_d  = clrp_q ? 1'b0 : (irq_q | (|(flags_q & mask_q)));
      if (clrp_q) flags_d = '0;
      clrp_d = 1'b0;
      for (int i = 0; i < N; i++) begin
        armed_d[i] = start_q[i];
        pulse_d[i] = uf[i];
        loadp_d[i] = 1'b0;
        if (loadp_q[i] || uf[i]) cnt_d[i] = latch_q[i];
        else if (ev[i])          cnt_d[i] = cnt_q[i] - 16'd1;
        if (uf[i]) begin
          flags_d[i] = 1'b1;
          tff_d[i]   = ~tff_q[i];
          if (oneshot_q[i]) begin
            start_d[i] = 1'b0;
            armed_d[i] = 1'b0;
          end
        end
      end
    end

    if (wr_en) begin
      if (rs == 5'd31) begin
        if (db_in[7]) mask_d = mask_q | db_in[6:0];
        else          mask_d = mask_q & ~db_in[6:0];
      end
      for (int i = 0; i < N; i++) begin
        if (rs == 5'(4*i)) latch_d[i][7:0] = db_in;
        if (rs == 5'(4*i+1)) begin
          latch_d[i][15:8] = db_in;
          if (!start_q[i]) cnt_d[i] = {db_in, latch_q[i][7:0]};
        end
        if (rs == 5'(4*i+2)) begin
          start_d[i]   = db_in[0];
          outen_d[i]   = db_in[1];
          tgl_d[i]     = db_in[2];
          oneshot_d[i] = db_in[3];
          src_d[i]     = db_in[6:5];
          if (db_in[4]) loadp_d[i] = 1'b1;
          // A fresh start re-arms the one-tick start pipeline and presets the toggle.
          if (db_in[0] && !start_q[i]) begin
            tff_d[i]   = 1'b1;
            armed_d[i] = 1'b0;
          end
          if (RELOAD_ON_STOP && !db_in[0] && start_q[i]) cnt_d[i] = latch_q[i];
        end
      end
    end

    if (rd_en) begin
      db_d = 8'h00;
      if (rs == 5'd31) begin
        db_d   = {irq_q, 1'b0, flags_q};
        clrp_d = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (rs == 5'(4*i))   db_d = cnt_q[i][7:0];
        if (rs == 5'(4*i+1)) db_d = cnt_q[i][15:8];
        if (rs == 5'(4*i+2))
          db_d = {1'b0, src_q[i], 1'b0, oneshot_q[i], tgl_q[i], outen_q[i], start_q[i]};
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      latch_q    <= '{default: 16'hFFFF};
      cnt_q      <= '{default: 16'h0000};
      src_q      <= '{default: 2'b00};
      start_q    <= '0;
      armed_q    <= '0;
      outen_q    <= '0;
      tgl_q      <= '0;
      oneshot_q  <= '0;
      loadp_q    <= '0;
      tff_q      <= '0;
      pulse_q    <= '0;
      flags_q    <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
      clrp_q     <= 1'b0;
      cnt_prev_q <= 1'b0;
      cntp_q     <= 1'b0;
      db_q       <= 8'h00;
    end else begin
      latch_q    <= latch_d;
      cnt_q      <= cnt_d;
      src_q      <= src_d;
      start_q    <= start_d;
      armed_q    <= armed_d;
      outen_q    <= outen_d;
      tgl_q      <= tgl_d;
      oneshot_q  <= oneshot_d;
      loadp_q    <= loadp_d;
      tff_q      <= tff_d;
      pulse_q    <= pulse_d;
      flags_q    <= flags_d;
      mask_q     <= mask_d;
      irq_q      <= irq_d;
      clrp_q     <= clrp_d;
      cnt_prev_q <= cnt_in;
      cntp_q     <= cntp_d;
      db_q       <= db_d;
    end
  end

  always_comb begin
    tout = '0;
    for (int i = 0; i < N; i++)
      tout[i] = outen_q[i] & (tgl_q[i] ? tff_q[i] : pulse_q[i]);
  end

  assign db_out = db_q;
  assign irq_n  = ~irq_q;

endmodule

// File: tb/tb_cia_timer_bank.sv
// Scoreboard bench for cia_timer_bank: a tick-indexed reference model predicts
// every read and the tout/irq_n state after every phi2 tick.
module tb_cia_timer_bank;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         res_n = 1'b0;
  logic         phi2_p = 1'b0, phi2_n = 1'b0, cs_n = 1'b1, rw = 1'b1, cnt_in = 1'b0;
  logic [4:0]   rs = 5'd0;
  logic [7:0]   db_in = 8'h00;
  logic [7:0]   db_out;
  logic [N-1:0] tout;
  logic         irq_n;

  cia_timer_bank #(.NUM_TIMERS(N), .RELOAD_ON_STOP(1'b0)) dut (
    .clk(clk), .res_n(res_n), .phi2_p(phi2_p), .phi2_n(phi2_n), .cs_n(cs_n),
    .rw(rw), .rs(rs), .db_in(db_in), .db_out(db_out), .cnt_in(cnt_in),
    .tout(tout), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference model: state kept as plain values, counting gated by tick index.
  logic [15:0] m_lat [N];
  logic [15:0] m_cnt [N];
  int          m_src [N];
  int          m_run_from [N];
  bit          m_start [N], m_outen [N], m_tgl [N], m_os [N], m_loadp [N], m_tff [N], m_pulse [N];
  bit   [6:0]  m_flags, m_mask;
  bit          m_irq, m_clr, m_cntedge;
  int          k = 0;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_lat[i] = 16'hFFFF; m_cnt[i] = 16'h0000; m_src[i] = 0; m_run_from[i] = 0;
      m_start[i] = 0; m_outen[i] = 0; m_tgl[i] = 0; m_os[i] = 0;
      m_loadp[i] = 0; m_tff[i] = 0; m_pulse[i] = 0;
    end
    m_flags = '0; m_mask = '0; m_irq = 0; m_clr = 0; m_cntedge = 0;
  endfunction

  function automatic void model_tick();
    bit prev, act, fired;
    k++;
    m_irq = m_clr ? 1'b0 : (m_irq | ((m_flags & m_mask) != 0));
    if (m_clr) m_flags = '0;
    m_clr = 0;
    prev  = 0;
    for (int i = 0; i < N; i++) begin
      case (m_src[i])
        0:       act = 1;
        1:       act = m_cntedge;
        2:       act = prev;
        default: act = prev && cnt_in;
      endcase
      act   = act && m_start[i] && (k >= m_run_from[i]);
      fired = act && (m_cnt[i] == 0);
      if (m_loadp[i] || fired) m_cnt[i] = m_lat[i];
      else if (act)            m_cnt[i] = m_cnt[i] - 1;
      m_loadp[i] = 0;
      m_pulse[i] = fired;
      if (fired) begin
        m_flags[i] = 1;
        m_tff[i]   = !m_tff[i];
        if (m_os[i]) m_start[i] = 0;
      end
      prev = fired;
    end
    m_cntedge = 0;
  endfunction

  function automatic logic [N:0] model_out();
    logic [N:0] o;
    o[N] = !m_irq;
    for (int i = 0; i < N; i++) o[i] = m_outen[i] && (m_tgl[i] ? m_tff[i] : m_pulse[i]);
    return o;
  endfunction

  function automatic void model_write(input int a, input logic [7:0] d);
    int ch, reg_sel;
    ch = a / 4;
    reg_sel = a % 4;
    if (a == 31) begin
      if (d[7]) m_mask = m_mask | d[6:0];
      else      m_mask = m_mask & ~d[6:0];
    end else if (ch < N && reg_sel != 3) begin
      case (reg_sel)
        0: m_lat[ch][7:0] = d;
        1: begin
          m_lat[ch][15:8] = d;
          if (!m_start[ch]) m_cnt[ch] = m_lat[ch];
        end
        default: begin
          if (d[0] && !m_start[ch]) begin
            m_tff[ch] = 1;
            m_run_from[ch] = k + 2;
          end
          m_start[ch] = d[0]; m_outen[ch] = d[1]; m_tgl[ch] = d[2]; m_os[ch] = d[3];
          m_src[ch] = int'(d[6:5]);
          if (d[4]) m_loadp[ch] = 1;
        end
      endcase
    end
  endfunction

  function automatic logic [7:0] model_read(input int a);
    int ch, reg_sel;
    ch = a / 4;
    reg_sel = a % 4;
    if (a == 31) begin
      m_clr = 1;
      return {m_irq, 1'b0, m_flags};
    end
    if (ch >= N || reg_sel == 3) return 8'h00;
    case (reg_sel)
      0:       return m_cnt[ch][7:0];
      1:       return m_cnt[ch][15:8];
      default: return {1'b0, 2'(m_src[ch]), 1'b0, m_os[ch], m_tgl[ch], m_outen[ch], m_start[ch]};
    endcase
  endfunction

  logic [7:0] q_rd [$];
  logic [N:0] q_out [$];
  logic       p_seen = 1'b0, r_seen = 1'b0;

  always @(posedge clk) begin
    p_seen <= phi2_p;
    r_seen <= phi2_n & ~cs_n & rw;
  end

  always @(negedge clk) begin
    if (p_seen) begin
      if (q_out.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL out_queue: tick seen with no expectation queued");
      end else check("tout_irq_n", {irq_n, tout}, q_out.pop_front());
    end
    if (r_seen) begin
      if (q_rd.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rd_queue: read seen with no expectation queued");
      end else check("db_out", db_out, q_rd.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #2;
    phi2_p = 1'b1;
    model_tick();
    q_out.push_back(model_out());
    @(posedge clk); #2;
    phi2_p = 1'b0;
  endtask

  task automatic bus_wr(input int a, input logic [7:0] d);
    @(posedge clk); #2;
    cs_n = 1'b0; rw = 1'b0; rs = 5'(a); db_in = d; phi2_n = 1'b1;
    model_write(a, d);
    @(posedge clk); #2;
    phi2_n = 1'b0; cs_n = 1'b1; rw = 1'b1;
  endtask

  task automatic bus_rd(input int a);
    @(posedge clk); #2;
    cs_n = 1'b0; rw = 1'b1; rs = 5'(a); phi2_n = 1'b1;
    q_rd.push_back(model_read(a));
    @(posedge clk); #2;
    phi2_n = 1'b0; cs_n = 1'b1;
  endtask

  task automatic set_cnt(input logic v);
    @(posedge clk); #2;
    if (v && !cnt_in) m_cntedge = 1;
    cnt_in = v;
  endtask

  task automatic setup_ch(input int ch, input logic [15:0] lat, input logic [7:0] ctrl);
    bus_wr(4*ch + 2, 8'h00);
    bus_wr(4*ch, lat[7:0]);
    bus_wr(4*ch + 1, lat[15:8]);
    bus_wr(4*ch + 2, ctrl);
  endtask

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #3;
    check("reset_db_out", db_out, 8'h00);
    check("reset_tout", tout, '0);
    check("reset_irq_n", irq_n, 1'b1);
    res_n = 1'b1;
    for (int a = 0; a < 32; a++) bus_rd(a);

    // Period: latch 3 in pulse mode.
    setup_ch(0, 16'd3, 8'h03);
    for (int t = 0; t < 12; t++) begin tick(); bus_rd(0); end
    bus_wr(2, 8'h00);

    // One-shot: latch 2.
    setup_ch(0, 16'd2, 8'h0B);
    for (int t = 0; t < 8; t++) begin tick(); bus_rd(0); bus_rd(2); end
    bus_rd(31);
    tick();
    bus_rd(31);

    // Cascade chain ch0 -> ch1 -> ch2.
    setup_ch(2, 16'd0, 8'h43);
    setup_ch(1, 16'd2, 8'h43);
    setup_ch(0, 16'd1, 8'h01);
    for (int t = 0; t < 14; t++) begin tick(); bus_rd(31); end
    for (int ch = 0; ch < 3; ch++) bus_wr(4*ch + 2, 8'h00);

    // Interrupt on ch1 with ICR reads at shifting phases.
    bus_rd(31); tick();
    bus_wr(31, 8'h82);
    setup_ch(1, 16'd2, 8'h03);
    for (int t = 0; t < 20; t++) begin
      tick();
      if (t % 5 == 2) bus_rd(31);
    end
    bus_wr(6, 8'h00);
    bus_wr(31, 8'h7F);

    // Gated CNT with toggle output on ch1, CNT-edge source on ch3.
    setup_ch(1, 16'd1, 8'h67);
    setup_ch(3, 16'd1, 8'h23);
    setup_ch(0, 16'd1, 8'h01);
    for (int t = 0; t < 24; t++) begin
      if (t == 5) set_cnt(1'b1);
      if (t > 12) set_cnt(1'($urandom_range(0, 1)));
      tick();
      bus_rd(4);
    end

    // Randomised register traffic.
    for (int n = 0; n < 300; n++) begin
      int r, a;
      r = $urandom_range(0, 9);
      if (r == 4) begin
        a = 4 * $urandom_range(0, N - 1) + $urandom_range(0, 2);
        if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 31);
        if (a % 4 == 0)      bus_wr(a, 8'($urandom_range(0, 5)));
        else if (a % 4 == 1) bus_wr(a, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
        else                 bus_wr(a, 8'($urandom));
      end else if (r == 5 || r == 6) bus_rd($urandom_range(0, 31));
      else if (r == 7) set_cnt(1'($urandom_range(0, 1)));
      else tick();
    end

    // Asynchronous reset mid-count with irq asserted and tout high.
    bus_wr(31, 8'hFF);
    setup_ch(0, 16'd0, 8'h07);
    for (int t = 0; t < 5; t++) tick();
    bus_rd(2);
    @(posedge clk); #3;
    res_n = 1'b0;
    #1;
    check("async_rst_db_out", db_out, 8'h00);
    check("async_rst_tout", tout, '0);
    check("async_rst_irq_n", irq_n, 1'b1);
    cnt_in = 1'b0;
    m_reset();
    #20;
    @(posedge clk); #2;
    res_n = 1'b1;
    bus_rd(0); bus_rd(1); bus_rd(2); bus_rd(31);
    for (int t = 0; t < 3; t++) tick();
    bus_rd(0);

    repeat (4) @(posedge clk);
    #1;
    check("rd_queue_drained", q_rd.size(), 0);
    check("out_queue_drained", q_out.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
